// File: rtl/mem_resp_queue.sv
// mem_resp_queue: in-order memory response queue for the MEM stage.
// Tracks up to DEPTH data-sram requests already accepted by the sram-like
// interface and captures their data_ok responses in issue order. Responses
// that belong to flushed requests are discarded with a cancel counter. The
// head entry is presented to WB aligned and sign-extended, with a byte mask.
// Optional feature macro: MEM_RESP_UNALIGNED_LD_EN enables lwl/lwr merging;
// without it lwl/lwr entries behave as lw.
module mem_resp_queue #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_is_load,
  input  logic [6:0]       req_ld_op,
  input  logic [1:0]       req_addr_lo,
  input  logic [4:0]       req_dest,
  input  logic [31:0]      req_pc,
  input  logic             data_ok,
  input  logic [31:0]      rdata,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [3:0]       out_rf_we,
  output logic [4:0]       out_dest,
  output logic [31:0]      out_pc,
  output logic [PTR_W:0]   count,
  output logic             err_unexpected
);

  // one-hot positions inside ld_op = {lw, lb, lbu, lh, lhu, lwl, lwr}
  localparam int OP_LW  = 6;
  localparam int OP_LB  = 5;
  localparam int OP_LBU = 4;
  localparam int OP_LH  = 3;
  localparam int OP_LHU = 2;
  localparam int OP_LWL = 1;
  localparam int OP_LWR = 0;

  logic             r_isLoad [DEPTH];
  logic [6:0]       r_ldOp   [DEPTH];
  logic [1:0]       r_addrLo [DEPTH];
  logic [4:0]       r_dest   [DEPTH];
  logic [31:0]      r_pc     [DEPTH];
  logic [31:0]      r_rdata  [DEPTH];
  logic             r_got    [DEPTH];

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W-1:0] r_resp;
  logic [PTR_W:0]   r_count;
  // entries between resp and tail, i.e. still waiting for data
  logic [PTR_W:0]   r_pend;
  // responses still owed by sram to requests that were flushed
  logic [PTR_W:0]   r_cancel;
  logic             r_err;

  logic             w_enq;
  logic             w_fill;
  logic             w_drop;
  logic             w_unexp;
  logic             w_retire;
  logic [PTR_W:0]   w_total;
  logic [PTR_W+1:0] w_cancelFlush;
  logic [31:0]      w_hd;
  logic [1:0]       w_p;
  logic [6:0]       w_op;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;

  assign w_total   = r_count + r_cancel;
  assign req_ready = w_total < (PTR_W+1)'(DEPTH);

  // The oldest-outstanding rule means a response is only unexpected when
  // neither a cancelled nor a live request is waiting, flush or not.
  assign w_unexp  = data_ok & (r_cancel == '0) & (r_pend == '0);
  assign w_enq    = req_valid & req_ready & ~flush;
  assign w_drop   = data_ok & (r_cancel != '0) & ~flush;
  assign w_fill   = data_ok & (r_cancel == '0) & (r_pend != '0) & ~flush;
  assign w_retire = out_valid & out_ready;

  // Every live waiting entry plus a request accepted this cycle turns into a
  // cancelled response; a response arriving now pays off one of them.
  assign w_cancelFlush = (PTR_W+2)'(r_cancel) + (PTR_W+2)'(r_pend)
                       + (PTR_W+2)'(req_valid)
                       - (PTR_W+2)'(data_ok & ~w_unexp);

  assign out_valid      = (r_count != '0) & r_got[r_head] & ~flush;
  assign out_dest       = r_dest[r_head];
  assign out_pc         = r_pc[r_head];
  assign count          = r_count;
  assign err_unexpected = r_err;

  assign w_hd   = r_rdata[r_head];
  assign w_p    = r_addrLo[r_head];
  assign w_op   = r_ldOp[r_head];
  assign w_byte = 8'(w_hd >> {w_p, 3'b000});
  assign w_half = w_p[1] ? w_hd[31:16] : w_hd[15:0];

  // Align and extend the head entry's data and build the register byte mask
  always_comb begin
    out_result = '0;
    out_rf_we  = '0;
    if (r_isLoad[r_head]) begin
      out_rf_we  = 4'hF;
      out_result = w_hd;
      if (w_op[OP_LB] | w_op[OP_LBU]) begin
        out_result = {{24{w_op[OP_LB] & w_byte[7]}}, w_byte};
      end else if (w_op[OP_LH] | w_op[OP_LHU]) begin
        out_result = {{16{w_op[OP_LH] & w_half[15]}}, w_half};
`ifdef MEM_RESP_UNALIGNED_LD_EN
      end else if (w_op[OP_LWL]) begin
        out_result = w_hd << {2'd3 - w_p, 3'b000};
        out_rf_we  = {1'b1, w_p != 2'd0, w_p[1], w_p == 2'd3};
      end else if (w_op[OP_LWR]) begin
        out_result = w_hd >> {w_p, 3'b000};
        out_rf_we  = {w_p == 2'd0, ~w_p[1], w_p != 2'd3, 1'b1};
      end else if (w_op[OP_LW]) begin
        out_result = w_hd;
`else
      end else if (w_op[OP_LW] | w_op[OP_LWL] | w_op[OP_LWR]) begin
        out_result = w_hd;
`endif
      end
    end
  end

  // Pointer, counter and storage updates; flush collapses the queue
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_resp   <= '0;
      r_count  <= '0;
      r_pend   <= '0;
      r_cancel <= '0;
      r_err    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_isLoad[i] <= 1'b0;
        r_ldOp[i]   <= '0;
        r_addrLo[i] <= '0;
        r_dest[i]   <= '0;
        r_pc[i]     <= '0;
        r_rdata[i]  <= '0;
        r_got[i]    <= 1'b0;
      end
    end else begin
      if (w_unexp) begin
        r_err <= 1'b1;
      end
      if (flush) begin
        r_head   <= r_tail;
        r_resp   <= r_tail;
        r_count  <= '0;
        r_pend   <= '0;
        r_cancel <= w_cancelFlush[PTR_W:0];
      end else begin
        if (w_enq) begin
          r_isLoad[r_tail] <= req_is_load;
          r_ldOp[r_tail]   <= req_ld_op;
          r_addrLo[r_tail] <= req_addr_lo;
          r_dest[r_tail]   <= req_dest;
          r_pc[r_tail]     <= req_pc;
          r_got[r_tail]    <= 1'b0;
          r_tail           <= r_tail + 1'b1;
        end
        if (w_fill) begin
          r_rdata[r_resp] <= rdata;
          r_got[r_resp]   <= 1'b1;
          r_resp          <= r_resp + 1'b1;
        end
        if (w_retire) begin
          r_head <= r_head + 1'b1;
        end
        r_count  <= r_count + (PTR_W+1)'(w_enq) - (PTR_W+1)'(w_retire);
        r_pend   <= r_pend + (PTR_W+1)'(w_enq) - (PTR_W+1)'(w_fill);
        r_cancel <= r_cancel - (PTR_W+1)'(w_drop);
      end
    end
  end

endmodule

// File: tb/tb_mem_resp_queue.sv
// tb_mem_resp_queue: scoreboard bench for mem_resp_queue. The bench plays the
// data-sram: every accepted request gets its response data chosen up front and
// is answered in order later. A reference model of live entries and of
// responses owed to flushed requests predicts every WB output.
module tb_mem_resp_queue;

  localparam int DEPTH = 4;
  localparam logic [6:0] LW  = 7'b1000000;
  localparam logic [6:0] LB  = 7'b0100000;
  localparam logic [6:0] LBU = 7'b0010000;
  localparam logic [6:0] LH  = 7'b0001000;
  localparam logic [6:0] LHU = 7'b0000100;
  localparam logic [6:0] LWL = 7'b0000010;
  localparam logic [6:0] LWR = 7'b0000001;

  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_load;
  logic [6:0]  req_ld_op;
  logic [1:0]  req_addr_lo;
  logic [4:0]  req_dest;
  logic [31:0] req_pc;
  logic        data_ok;
  logic [31:0] rdata;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_rf_we;
  logic [4:0]  out_dest;
  logic [31:0] out_pc;
  logic [2:0]  count;
  logic        err_unexpected;

  typedef struct {
    logic [31:0] data;
    bit          dead;
  } sram_t;

  typedef struct {
    logic [31:0] result;
    logic [3:0]  mask;
    logic [4:0]  dest;
    logic [31:0] pc;
    bit          got;
  } exp_t;

  sram_t sramQ[$];
  exp_t  expQ[$];
  int    nChecks;
  int    nFails;
  bit    expectErr;
  bit    monOn;
  bit    forceDok;
  int    nDead;
  bit    expV;

  mem_resp_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_load(req_is_load),
    .req_ld_op(req_ld_op), .req_addr_lo(req_addr_lo), .req_dest(req_dest),
    .req_pc(req_pc), .data_ok(data_ok), .rdata(rdata), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rf_we(out_rf_we), .out_dest(out_dest), .out_pc(out_pc),
    .count(count), .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // What WB should receive, derived from the load rules byte by byte
  function automatic void refModel(input logic isLoad, input logic [6:0] op,
                                   input logic [1:0] p, input logic [31:0] d,
                                   output logic [31:0] res, output logic [3:0] mask);
    int unsigned b;
    int unsigned h;
    int unsigned sh;
    res  = d;
    mask = 4'hF;
    b = (d >> (8 * p)) & 32'hFF;
    h = (p >= 2) ? (d >> 16) : (d & 32'hFFFF);
    sh = 8 * (3 - int'(p));
    if (!isLoad) begin
      res  = 32'h0;
      mask = 4'h0;
    end else if (op == LB) res = (b >= 128) ? (b | 32'hFFFF_FF00) : b;
    else if (op == LBU) res = b;
    else if (op == LH) res = (h >= 32768) ? (h | 32'hFFFF_0000) : h;
    else if (op == LHU) res = h;
`ifdef MEM_RESP_UNALIGNED_LD_EN
    else if (op == LWL) begin
      res = d << sh;
      for (int i = 0; i < 4; i++) mask[i] = (i >= 3 - int'(p));
    end else if (op == LWR) begin
      res = d >> (8 * p);
      for (int i = 0; i < 4; i++) mask[i] = (i <= 3 - int'(p));
    end
`endif
  endfunction

  // One clock cycle of stimulus; the model is updated at the edge where the
  // DUT registers these inputs.
  task automatic applyStimulus(input bit reqV, input logic isL, input logic [6:0] op,
                               input logic [1:0] p, input logic [31:0] reqData,
                               input bit dok, input bit fl, input bit ordy);
    bit          doReq;
    bit          doData;
    sram_t       s;
    exp_t        e;
    logic [31:0] r;
    logic [3:0]  m;
    doReq  = reqV && req_ready;
    doData = dok && (sramQ.size() > 0 || forceDok);
    req_valid   = doReq;
    req_is_load = isL;
    req_ld_op   = op;
    req_addr_lo = p;
    req_dest    = 5'($urandom);
    req_pc      = $urandom;
    data_ok     = doData;
    rdata       = (doData && sramQ.size() > 0) ? sramQ[0].data : $urandom;
    flush       = fl;
    out_ready   = ordy;
    @(posedge clk);
    if (doData) begin
      if (sramQ.size() == 0) begin
        expectErr = 1'b1;
      end else begin
        s = sramQ.pop_front();
        if (!s.dead) begin
          for (int i = 0; i < expQ.size(); i++) begin
            if (!expQ[i].got) begin
              expQ[i].got = 1'b1;
              break;
            end
          end
        end
      end
    end
    if (doReq) begin
      s.data = reqData;
      s.dead = fl;
      sramQ.push_back(s);
      if (!fl) begin
        refModel(isL, op, p, reqData, r, m);
        e.result = r;
        e.mask   = m;
        e.dest   = req_dest;
        e.pc     = req_pc;
        e.got    = 1'b0;
        expQ.push_back(e);
      end
    end
    if (fl) begin
      foreach (sramQ[i]) sramQ[i].dead = 1'b1;
      expQ.delete();
    end
    #1;
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) applyStimulus(0, 1, LW, 0, 0, 0, 0, ordy);
  endtask

  // Monitor: compares the DUT against the scoreboard every cycle and pops
  // the head expectation whenever WB accepts an entry.
  always @(negedge clk) begin
    if (monOn) begin
      nDead = 0;
      foreach (sramQ[i]) if (sramQ[i].dead) nDead++;
      checkOutput("count", 32'(count), expQ.size());
      checkOutput("req_ready", 32'(req_ready), 32'(expQ.size() + nDead < DEPTH));
      expV = !flush && expQ.size() > 0 && expQ[0].got;
      checkOutput("out_valid", 32'(out_valid), 32'(expV));
      checkOutput("err_unexpected", 32'(err_unexpected), 32'(expectErr));
      if (expV && out_valid) begin
        checkOutput("out_result", out_result, expQ[0].result);
        checkOutput("out_rf_we", 32'(out_rf_we), 32'(expQ[0].mask));
        checkOutput("out_dest", 32'(out_dest), 32'(expQ[0].dest));
        checkOutput("out_pc", out_pc, expQ[0].pc);
        if (out_ready) void'(expQ.pop_front());
      end
    end
  end

  initial begin
    logic [6:0] op;
    bit         drained;
    clk = 0; resetn = 0; nChecks = 0; nFails = 0; expectErr = 0; monOn = 0; forceDok = 0;
    req_valid = 0; req_is_load = 0; req_ld_op = 0; req_addr_lo = 0; req_dest = 0;
    req_pc = 0; data_ok = 0; rdata = 0; flush = 0; out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] checking reset state");
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_req_ready", 32'(req_ready), 1);
    checkOutput("rst_count", 32'(count), 0);
    checkOutput("rst_out_result", out_result, 0);
    checkOutput("rst_out_rf_we", 32'(out_rf_we), 0);
    checkOutput("rst_out_dest", 32'(out_dest), 0);
    checkOutput("rst_out_pc", out_pc, 0);
    checkOutput("rst_err", 32'(err_unexpected), 0);
    resetn = 1;
    monOn  = 1;

    $display("[TB] single lw");
    applyStimulus(1, 1, LW, 0, 32'h8000_00F1, 0, 0, 1);
    idle(1, 1);
    applyStimulus(0, 1, LW, 0, 0, 1, 0, 1);
    checkOutput("lw_direct_valid", 32'(out_valid), 1);
    checkOutput("lw_direct_result", out_result, 32'h8000_00F1);
    idle(2, 1);

    $display("[TB] four back-to-back sub-word loads");
    applyStimulus(1, 1, LB,  3, 32'h8765_4321, 0, 0, 1);
    applyStimulus(1, 1, LBU, 3, 32'h8765_4321, 0, 0, 1);
    applyStimulus(1, 1, LH,  2, 32'h8765_4321, 0, 0, 1);
    applyStimulus(1, 1, LHU, 2, 32'h8765_4321, 0, 0, 1);
    checkOutput("full_req_ready", 32'(req_ready), 0);
    repeat (4) applyStimulus(0, 1, LW, 0, 0, 1, 0, 1);
    idle(2, 1);

    $display("[TB] flush with three entries, one complete");
    repeat (3) applyStimulus(1, 1, LW, 0, $urandom, 0, 0, 0);
    applyStimulus(0, 1, LW, 0, 0, 1, 0, 0);
    applyStimulus(0, 1, LW, 0, 0, 0, 1, 0);
    checkOutput("flush_count", 32'(count), 0);
    repeat (2) applyStimulus(0, 1, LW, 0, 0, 1, 0, 1);
    applyStimulus(1, 1, LW, 0, 32'hCAFE_F00D, 0, 0, 1);
    applyStimulus(0, 1, LW, 0, 0, 1, 0, 1);
    idle(2, 1);

    $display("[TB] flush coincident with request and response");
    repeat (2) applyStimulus(1, 1, LW, 0, $urandom, 0, 0, 1);
    applyStimulus(1, 1, LW, 0, $urandom, 1, 1, 1);
    repeat (2) applyStimulus(0, 1, LW, 0, 0, 1, 0, 1);
    applyStimulus(1, 1, LH, 0, 32'h0000_9ABC, 0, 0, 1);
    applyStimulus(0, 1, LW, 0, 0, 1, 0, 1);
    idle(2, 1);

    $display("[TB] lwl / lwr");
    applyStimulus(1, 1, LWL, 1, 32'h4433_2211, 0, 0, 1);
    applyStimulus(1, 1, LWR, 2, 32'h4433_2211, 1, 0, 1);
    applyStimulus(0, 1, LW, 0, 0, 1, 0, 1);
    idle(2, 1);

    $display("[TB] stall with four complete entries");
    repeat (4) applyStimulus(1, 1, 7'(1 << $urandom_range(0, 6)), 2'($urandom), $urandom, 0, 0, 0);
    repeat (4) applyStimulus(0, 1, LW, 0, 0, 1, 0, 0);
    idle(5, 0);
    idle(6, 1);

    $display("[TB] random traffic");
    for (int c = 0; c < 3000; c++) begin
      op = 7'(1 << $urandom_range(0, 6));
      applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, op,
                    2'($urandom), $urandom, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0);
    end

    drained = 0;
    for (int c = 0; c < 200 && !drained; c++) begin
      applyStimulus(0, 1, LW, 0, 0, 1, 0, 1);
      drained = (sramQ.size() == 0) && (expQ.size() == 0);
    end
    checkOutput("drain_done", 32'(drained), 1);

    $display("[TB] response with nothing pending");
    forceDok = 1;
    applyStimulus(0, 1, LW, 0, 0, 1, 0, 1);
    forceDok = 0;
    idle(2, 1);
    checkOutput("err_sticky", 32'(err_unexpected), 1);

    monOn = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/mem_resp_queue.md
# mem_resp_queue

Parametrised in-order memory response queue for the MEM stage. It tracks up to DEPTH outstanding data-sram requests that the sram-like interface has already accepted, and captures their data_ok responses in issue order. It discards responses that belong to flushed requests using a cancel counter, and presents load results to WB one at a time, aligned and sign-extended, with a per-byte register write mask. It replaces the single-outstanding MEM-stage handshake, which used a one-bit cancel flag.

## Interface
- DEPTH, 4, maximum outstanding requests (power of two, ≥2); PTR_W = log2(DEPTH).
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- req_valid  in  1  a request was accepted by data-sram this cycle (addr_ok handshake done); enqueue it.
- req_ready  out  1  queue can take another request; EX issues to data-sram only when high.
- req_is_load  in  1  1 = load, 0 = store.
- req_ld_op  in  7  one-hot {lw, lb, lbu, lh, lhu, lwl, lwr}.
- req_addr_lo  in  2  address bits [1:0].
- req_dest  in  5  destination GPR.
- req_pc  in  32  instruction PC.
- data_ok  in  1  one response from data-sram this cycle.
- rdata  in  32  response data, valid with data_ok.
- flush  in  1  exception/eret flush; kills every queued entry.
- out_valid  out  1  head entry has its response.
- out_ready  in  1  WB accepts the head entry.
- out_result  out  32  aligned load result.
- out_rf_we  out  4  byte write enables.
- out_dest  out  5  head entry destination.
- out_pc  out  32  head entry PC.
- count  out  PTR_W+1  live entries.
- err_unexpected  out  1  sticky: a data_ok arrived with nothing pending.

## Operation
- Storage is DEPTH entries holding {is_load, ld_op, addr_lo, dest, pc, rdata, got}. Three pointers track it: head (retire), tail (enqueue) and resp (oldest entry still waiting for data). All wrap modulo DEPTH.
- Enqueue happens when req_valid && req_ready. The entry is written at tail with got=0, then tail increments.
- req_ready = (count + cancel_cnt) < DEPTH. This limits total sram-side outstanding requests to DEPTH, so cancel_cnt ≤ DEPTH.
- data_ok handling:
  - If cancel_cnt > 0: the response is dropped and cancel_cnt decrements.
  - Else if resp ≠ tail: rdata is written into entry resp, its got bit is set, and resp increments.
  - Else: the response is ignored and err_unexpected is set.
- Retire happens when out_valid && out_ready. Head increments and count decrements.
- Flush takes priority over enqueue, fill and retire in the same cycle:
  - head, resp and tail become equal and count becomes 0.
  - cancel_cnt_next = cancel_cnt + (entries with got=0) + (req_valid ? 1 : 0) − (data_ok ? 1 : 0).
  - A data_ok arriving in the flush cycle is charged to the oldest outstanding request: first a cancelled one, otherwise the oldest flushed one.
  - Nothing enqueues and nothing retires in the flush cycle. out_valid is forced to 0 during flush.
- Alignment is a function of the head entry, with p = addr_lo and d = rdata:
  - lb / lbu: byte p of d, sign- or zero-extended.
  - lh / lhu: d[15:0] if p[1]=0, else d[31:16]; sign- or zero-extended.
  - lw: d.
  - lwl: d shifted left by 8*(3−p); mask {1, p≠0, p[1], p==3}.
  - lwr: d shifted right by 8*p; mask {p==0, ~p[1], p≠3, 1}.
  - Other loads: mask 4'hF. Stores: mask 4'h0 and out_result = 0.

## Timing
- On reset: count=0, cancel_cnt=0, all pointers 0, all got bits 0, err_unexpected=0.
- Output values after reset: out_valid=0, req_ready=1, out_result/out_rf_we/out_dest/out_pc all 0 (storage is cleared).
- Latency: data_ok in cycle N for the head entry gives out_valid in cycle N+1. There is no same-cycle bypass.
- Throughput: one enqueue, one fill and one retire can all happen in the same cycle.
- Full: when count + cancel_cnt == DEPTH, req_ready=0. If a retire happens in that cycle, req_ready rises in the next cycle. req_ready is a registered-state function only and does not combinationally depend on out_ready.
- Empty: out_valid=0. A retire and an enqueue in the same cycle leave count unchanged.
- Outputs remain stable while out_valid && !out_ready.
- A reset in the middle of operation abandons all state. Any data_ok after reset with nothing pending sets err_unexpected; the system reset must also reset the sram so this cannot occur.

## Configuration
- MEM_RESP_UNALIGNED_LD_EN:
  - Defined: lwl/lwr use the merge masks and shifts given under Operation.
  - Undefined: the lwl and lwr bits of ld_op are ignored. Such an entry behaves as lw (result d, mask 4'hF), and the shift/mask logic is not built.

## Test plan
- Single lw: enqueue lw with p=0; data_ok with 0x8000_00F1 two cycles later → next cycle out_valid=1, out_result=0x8000_00F1, out_rf_we=4'hF.
- Four back-to-back loads (lb p=3, lbu p=3, lh p=2, lhu p=2), all with rdata 0x8765_4321, and out_ready=1:
  - Results in order 0xFFFF_FF87, 0x0000_0087, 0xFFFF_8765, 0x0000_8765.
  - req_ready=0 while 4 are outstanding.
- Flush with 3 entries, 1 got: flush → count=0, cancel_cnt=2. The next two data_ok are dropped; the third fills a new lw entry correctly.
- Flush coincident with req_valid and data_ok while 2 entries are waiting → cancel_cnt=2, and out_valid stays 0 until a post-flush request responds.
- With MEM_RESP_UNALIGNED_LD_EN, using d=0x4433_2211:
  - lwl p=1 → result 0x2211_0000, mask 4'b1100.
  - lwr p=2 → result 0x0000_4433, mask 4'b0011.
  - Without the macro, both → result 0x4433_2211, mask 4'hF.
- Stall: out_ready=0 for 5 cycles with 4 entries complete → outputs are held, req_ready=0, and no response is lost. Releasing out_ready drains one entry per cycle.
